task_req_sequencer: RTL and testbench

// - Single-clock initiator feeding the toggle-based task/ack clock-domain crossing from its requesting side.
// - Queues argument words from a valid/ready client.
// - Issues one start pulse per word, holds the argument stable across the crossing, waits for the done pulse, counts completions.
// - Sits in the clkA domain between the bus client and the crossing block.

---
 rtl/task_req_pkg.sv | 16 +
 rtl/task_req_fifo.sv | 52 +++++
 rtl/task_req_sequencer.sv | 118 +++++++++++
 tb/tb_task_req_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/task_req_pkg.sv
// Shared types and default sizes for the task request sequencer.
package task_req_pkg;

   localparam int DATA_W_DEF    = 32;
   localparam int DEPTH_LOG_DEF = 2;
   localparam int CNT_W_DEF     = 16;
   localparam int TMO_CYC_DEF   = 4096;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      DRAIN     = 2'd3
   } reqState_t;

endpackage

// File: rtl/task_req_fifo.sv
// Synchronous request FIFO, DATA_W x 2**DEPTH_LOG, with extra-bit pointers
// so that full and empty can be told apart.
module task_req_fifo
   import task_req_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int DEPTH_LOG = DEPTH_LOG_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [DATA_W-1:0]    wrData,
   input  logic                 pop,
   output logic [DATA_W-1:0]    rdData,
   output logic                 full,
   output logic                 empty,
   output logic [DEPTH_LOG:0]   level
);

   localparam int DEPTH = 1 << DEPTH_LOG;

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [DEPTH_LOG:0] wrPtr;
   logic [DEPTH_LOG:0] rdPtr;
   logic               doPush;
   logic               doPop;

   assign full   = (wrPtr[DEPTH_LOG] != rdPtr[DEPTH_LOG]) &&
                   (wrPtr[DEPTH_LOG-1:0] == rdPtr[DEPTH_LOG-1:0]);
   assign empty  = (wrPtr == rdPtr);
   assign level  = wrPtr - rdPtr;
   assign rdData = mem[rdPtr[DEPTH_LOG-1:0]];
   assign doPush = push && !full;
   assign doPop  = pop && !empty;

   // Pointer bookkeeping; a same-cycle push and pop leave the level unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
      end
   end

   // Storage is data only and needs no reset
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr[DEPTH_LOG-1:0]] <= wrData;
   end

endmodule

// File: rtl/task_req_sequencer.sv
// Requester-side sequencer for the toggle task/ack crossing: queues client
// arguments, issues one start per word, holds the argument until completion
// and counts completions. Optional timeout monitor: TASK_REQ_TIMEOUT_EN.
module task_req_sequencer
   import task_req_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int DEPTH_LOG = DEPTH_LOG_DEF,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int TMO_CYC   = TMO_CYC_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   input  logic [DATA_W-1:0]    req_data,
   output logic                 req_ready,
   output logic                 task_start,
   output logic [DATA_W-1:0]    task_arg,
   input  logic                 task_busy,
   input  logic                 task_done,
   output logic [DEPTH_LOG:0]   fifo_level,
   output logic [CNT_W-1:0]     done_count,
   output logic                 timeout_err,
   input  logic                 err_clr
);

   reqState_t         state;
   reqState_t         stateNxt;
   logic              pop;
   logic              fifoFull;
   logic              fifoEmpty;
   logic [DATA_W-1:0] headData;

   assign req_ready  = !fifoFull;
   assign task_start = (state == ISSUE);

   task_req_fifo #(
      .DATA_W    (DATA_W),
      .DEPTH_LOG (DEPTH_LOG)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (req_valid && req_ready),
      .wrData (req_data),
      .pop    (pop),
      .rdData (headData),
      .full   (fifoFull),
      .empty  (fifoEmpty),
      .level  (fifo_level)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNxt;
   end

   // Next state; DRAIN holds off a new start until the crossing is idle again
   always_comb begin
      stateNxt = state;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            if (!fifoEmpty && !task_busy) begin
               pop      = 1'b1;
               stateNxt = ISSUE;
            end
         end
         ISSUE:     stateNxt = WAIT_DONE;
         WAIT_DONE: if (task_done) stateNxt = DRAIN;
         DRAIN:     if (!task_busy) stateNxt = IDLE;
         default:   stateNxt = IDLE;
      endcase
   end

   // Argument register: loads only on pop, held through IDLE afterwards
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   task_arg <= '0;
      else if (pop) task_arg <= headData;
   end

   // Completion counter; done pulses outside WAIT_DONE are stale or stray
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               done_count <= '0;
      else if ((state == WAIT_DONE) && task_done) done_count <= done_count + CNT_W'(1);
   end

`ifdef TASK_REQ_TIMEOUT_EN
   localparam int TMO_W = $clog2(TMO_CYC + 1);

   logic [TMO_W-1:0] tmoCnt;
   logic             tmoRun;
   logic             tmoHit;

   assign tmoRun = (state == WAIT_DONE) || (state == DRAIN);
   assign tmoHit = tmoRun && (tmoCnt == TMO_W'(TMO_CYC - 1));

   // Cycles spent waiting on the crossing, saturating at TMO_CYC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     tmoCnt <= '0;
      else if (state == ISSUE)                        tmoCnt <= '0;
      else if (tmoRun && (tmoCnt != TMO_W'(TMO_CYC))) tmoCnt <= tmoCnt + TMO_W'(1);
   end

   // Sticky flag only; the FSM keeps waiting, and a clear beats a new hit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       timeout_err <= 1'b0;
      else if (err_clr) timeout_err <= 1'b0;
      else if (tmoHit)  timeout_err <= 1'b1;
   end
`else
   logic unusedErrClr;

   assign unusedErrClr = err_clr;
   assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_task_req_sequencer.sv
// Scoreboard bench for task_req_sequencer with a behavioural model of the
// crossing (busy one cycle after start, done N cycles later, busy falls after done).
module tb_task_req_sequencer;

   localparam int DATA_W    = 32;
   localparam int DEPTH_LOG = 2;
   localparam int CNT_W     = 4;
   localparam int TMO_CYC   = 16;
   localparam int DEPTH     = 1 << DEPTH_LOG;
   localparam int CNT_MOD   = 1 << CNT_W;

   logic                 clk;
   logic                 rst_n;
   logic                 req_valid;
   logic [DATA_W-1:0]    req_data;
   logic                 req_ready;
   logic                 task_start;
   logic [DATA_W-1:0]    task_arg;
   logic                 task_busy;
   logic                 task_done;
   logic [DEPTH_LOG:0]   fifo_level;
   logic [CNT_W-1:0]     done_count;
   logic                 timeout_err;
   logic                 err_clr;

   task_req_sequencer #(
      .DATA_W    (DATA_W),
      .DEPTH_LOG (DEPTH_LOG),
      .CNT_W     (CNT_W),
      .TMO_CYC   (TMO_CYC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .task_start  (task_start),
      .task_arg    (task_arg),
      .task_busy   (task_busy),
      .task_done   (task_done),
      .fifo_level  (fifo_level),
      .done_count  (done_count),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   int checks;
   int errors;
   int cyc;
   logic [DATA_W-1:0] argQ [$];
   int cntQ [$];
   logic [DATA_W-1:0] lastArg;
   int startCount;
   int startEdge;
   int acceptEdge;
   bit hang;
   bit dblDone;
   bit pendBusy;
   bit liveTask;
   int respN;
   int respCnt;
   int expCnt;
   int strayReqs;
   int strayServed;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   // Crossing model, driven on the falling edge
   initial begin
      task_busy = 1'b0;
      task_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            expCnt   = 0;
            liveTask = 1'b0;
         end
         if (task_done) begin
            task_done = 1'b0;
            if (task_busy) begin
               task_busy = 1'b0;
               if (dblDone) begin
                  task_done = 1'b1;
                  cntQ.push_back(expCnt);
               end
            end
         end else if (pendBusy) begin
            pendBusy  = 1'b0;
            task_busy = 1'b1;
            respCnt   = (respN > 0) ? respN : int'($urandom_range(6, 1));
         end else if (task_busy) begin
            if (!hang) begin
               if (respCnt > 1) respCnt--;
               else begin
                  if (liveTask) expCnt = (expCnt + 1) % CNT_MOD;
                  liveTask  = 1'b0;
                  task_done = 1'b1;
                  cntQ.push_back(expCnt);
               end
            end
         end else if (strayServed != strayReqs) begin
            strayServed++;
            task_done = 1'b1;
            cntQ.push_back(expCnt);
         end
         if (task_start) begin
            pendBusy = 1'b1;
            liveTask = 1'b1;
         end
      end
   end

   // Monitor: sampled just after each rising edge
   initial begin
      lastArg = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) lastArg = '0;
         else if (task_start) begin
            startCount++;
            startEdge = cyc;
            chk("start_while_busy", 64'(task_busy), 64'd0);
            if (argQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_start: arg %0h issued with nothing queued", task_arg);
            end else lastArg = argQ.pop_front();
         end
         chk("task_arg", 64'(task_arg), 64'(lastArg));
         chk("fifo_level", 64'(fifo_level), 64'(argQ.size()));
         chk("req_ready", 64'(req_ready), 64'(argQ.size() < DEPTH));
         if (task_done) begin
            if (cntQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done_unmodelled: done_count %0d with no expectation", done_count);
            end else chk("done_count", 64'(done_count), 64'(cntQ.pop_front()));
         end
      end
   end

   // Caller is aligned to a falling edge
   task automatic pushWord(input logic [DATA_W-1:0] d);
      int t;
      t = 0;
      req_valid = 1'b1;
      req_data  = d;
      while (!req_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) begin
         req_valid = 1'b0;
         checks++;
         errors++;
         $display("FAIL push_timeout: req_ready %0b, required 1 for data %0h", req_ready, d);
      end else begin
         argQ.push_back(d);
         acceptEdge = cyc + 1;
         @(negedge clk);
         req_valid = 1'b0;
      end
   endtask

   task automatic waitStart(input int s0);
      int t;
      t = 0;
      while (startCount == s0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (startCount == s0) begin
         checks++;
         errors++;
         $display("FAIL start_timeout: start count %0d, required above %0d", startCount, s0);
      end
   endtask

   task automatic waitIdle();
      int t;
      t = 0;
      while ((argQ.size() != 0 || task_busy || pendBusy || task_done || task_start ||
              fifo_level != 0) && t < 4000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 4000) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: queue %0d busy %0b, required empty and idle", argQ.size(), task_busy);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic checkResetValues(input string tag);
      chk({tag, "_task_start"},  64'(task_start),  64'd0);
      chk({tag, "_task_arg"},    64'(task_arg),    64'd0);
      chk({tag, "_done_count"},  64'(done_count),  64'd0);
      chk({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
      chk({tag, "_fifo_level"},  64'(fifo_level),  64'd0);
      chk({tag, "_req_ready"},   64'(req_ready),   64'd1);
   endtask

   initial begin
      int s0;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_data  = '0;
      err_clr   = 1'b0;
      respN     = 5;
      repeat (3) @(negedge clk);
      checkResetValues("reset");
      rst_n = 1'b1;

      // Single task
      s0 = startCount;
      pushWord(32'hA5A5_0001);
      waitStart(s0);
      // the crossing samples the start two edges after the accepting edge
      chk("start_latency", 64'(startEdge + 1 - acceptEdge), 64'd2);
      chk("single_arg", 64'(task_arg), 64'hA5A5_0001);
      waitIdle();
      chk("single_done_count", 64'(done_count), 64'd1);

      // Fill the FIFO while the crossing makes no progress
      hang = 1'b1;
      for (int i = 0; i < 5; i++) pushWord(32'hF000_0000 + 32'(i));
      repeat (2) @(negedge clk);
      chk("full_level", 64'(fifo_level), 64'd4);
      chk("full_ready", 64'(req_ready), 64'd0);
      fork
         pushWord(32'hF000_0005);
         begin
            repeat (4) @(negedge clk);
            chk("blocked_ready", 64'(req_ready), 64'd0);
            hang = 1'b0;
         end
      join
      waitIdle();
      chk("fill_done_count", 64'(done_count), 64'(expCnt));

      // Stray done in IDLE, then a second done during DRAIN
      strayReqs++;
      repeat (4) @(negedge clk);
      chk("stray_done_count", 64'(done_count), 64'(expCnt));
      dblDone = 1'b1;
      pushWord(32'hD0D0_0001);
      waitIdle();
      dblDone = 1'b0;
      chk("double_done_count", 64'(done_count), 64'(expCnt));

      // Randomised traffic and responder latency
      respN = 0;
      s0 = startCount;
      repeat (30) begin
         repeat ($urandom_range(3, 0)) @(negedge clk);
         pushWord($urandom());
      end
      waitIdle();
      chk("random_starts", 64'(startCount - s0), 64'd30);
      chk("random_done_count", 64'(done_count), 64'(expCnt));

      // Timeout behaviour
      respN   = 5;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      @(negedge clk);
      chk("err_preclear", 64'(timeout_err), 64'd0);
      hang = 1'b1;
      s0 = startCount;
      pushWord(32'h7E57_0001);
      waitStart(s0);
`ifdef TASK_REQ_TIMEOUT_EN
      @(posedge clk);
      repeat (15) @(posedge clk);
      #1 chk("tmo_before", 64'(timeout_err), 64'd0);
      @(posedge clk);
      #1 chk("tmo_at", 64'(timeout_err), 64'd1);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("tmo_clear", 64'(timeout_err), 64'd0);
      repeat (5) @(negedge clk);
      chk("tmo_stays_clear", 64'(timeout_err), 64'd0);
`else
      repeat (40) @(negedge clk);
      chk("tmo_disabled", 64'(timeout_err), 64'd0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("tmo_disabled_clr", 64'(timeout_err), 64'd0);
`endif
      hang = 1'b0;
      waitIdle();
      chk("late_done_count", 64'(done_count), 64'(expCnt));

      // Reset in the middle of WAIT_DONE
      respN = 20;
      s0 = startCount;
      pushWord(32'hBEEF_0001);
      waitStart(s0);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      argQ.delete();
      #1 checkResetValues("midreset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      respN = 3;
      s0 = startCount;
      pushWord(32'hBEEF_0002);
      waitStart(s0);
      waitIdle();
      chk("post_reset_done_count", 64'(done_count), 64'(expCnt));

      // Counter wrap: 2**CNT_W completions from reset
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("wrap_start_count", 64'(done_count), 64'd0);
      respN = 0;
      s0 = startCount;
      repeat (CNT_MOD) pushWord($urandom());
      waitIdle();
      chk("wrap_starts", 64'(startCount - s0), 64'(CNT_MOD));
      chk("wrap_count", 64'(done_count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
